// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle between the ALU4CPU datapath (master)
// and the bit-serial add/subtract engine (slave).
interface serial_add_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, c_out, ovf, zero
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, c_out, ovf, zero
  );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract engine: one full-adder evaluation per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to compute signed overflow; otherwise ovf is tied low.
module serial_add_unit #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q,  c_out_d;
  logic             valid_q,  valid_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  // The single full-adder cell, fed from the operand LSBs and the carry flop.
  logic fa_sum;
  logic fa_cout;
  assign fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  logic last_bit;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    valid_d  = valid_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          a_sh_d   = bus.a;
          b_sh_d   = bus.op_sub ? ~bus.b : bus.b;
          carry_d  = bus.op_sub;
          cnt_d    = '0;
          result_d = '0;
          c_out_d  = 1'b0;
          valid_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          c_out_d = fa_cout;
          valid_d = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      valid_q  <= valid_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf    = ovf_q;
`else
  assign bus.ovf    = 1'b0;
`endif
  // valid_q keeps zero low out of reset, before any result has been produced.
  assign bus.zero   = valid_q && (state_q != ST_SHIFT) && (result_q == '0);

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (WIDTH=4); ovf expectations follow SERIAL_ADD_OVF_EN.
module tb_serial_add_unit;
  localparam int W = 4;

`ifdef SERIAL_ADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  serial_add_if #(.WIDTH(W)) sif ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a negedge, let the next posedge accept it, drop start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    sif.start  = 1'b1;
    sif.a      = a;
    sif.b      = b;
    sif.op_sub = sub;
    @(posedge clk);
    #1;
    sif.start  = 1'b0;
  endtask

  // Count posedges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (sif.done !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.start = 1'b0; sif.op_sub = 1'b0; sif.a = '0; sif.b = '0;
    #3;
    checks++;
    if ({sif.busy, sif.done, sif.result, sif.c_out, sif.ovf, sif.zero} !== 9'b0)
      $display("FAIL reset_outputs: got busy=%b done=%b result=%b c_out=%b ovf=%b zero=%b, want all 0",
               sif.busy, sif.done, sif.result, sif.c_out, sif.ovf, sif.zero);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sif.busy, sif.done, sif.zero} !== 3'b000)
      $display("FAIL idle_after_reset: got busy=%b done=%b zero=%b, want 000", sif.busy, sif.done, sif.zero);
    else passed++;
  endtask

  task automatic test_add_overflow();
    int edges;
    issue(4'b0111, 4'b0001, 1'b0);
    checks++;
    if (sif.busy !== 1'b1) $display("FAIL add_ovf_busy: got %b want 1", sif.busy);
    else passed++;
    wait_done(edges);
    checks++;
    if (edges !== W) $display("FAIL add_ovf_latency: got %0d edges want %0d", edges, W);
    else passed++;
    checks++;
    if ({sif.result, sif.c_out, sif.ovf, sif.zero} !== {4'b1000, 1'b0, OVF_ON, 1'b0})
      $display("FAIL add_ovf_result: got result=%b c_out=%b ovf=%b zero=%b want 1000 0 %b 0",
               sif.result, sif.c_out, sif.ovf, sif.zero, OVF_ON);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (sif.done !== 1'b0 || sif.result !== 4'b1000 || sif.ovf !== OVF_ON)
      $display("FAIL add_ovf_hold: got done=%b result=%b ovf=%b want 0 1000 %b", sif.done, sif.result, sif.ovf, OVF_ON);
    else passed++;
  endtask

  task automatic test_add_wrap();
    int edges;
    issue(4'b1111, 4'b0001, 1'b0);
    checks++;
    if (sif.zero !== 1'b0) $display("FAIL wrap_zero_busy: got %b want 0", sif.zero);
    else passed++;
    wait_done(edges);
    checks++;
    if ({sif.result, sif.c_out, sif.ovf, sif.zero} !== {4'b0000, 1'b1, 1'b0, 1'b1} || edges !== W)
      $display("FAIL add_wrap: got result=%b c_out=%b ovf=%b zero=%b edges=%0d want 0000 1 0 1 %0d",
               sif.result, sif.c_out, sif.ovf, sif.zero, edges, W);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sif.zero !== 1'b1 || sif.c_out !== 1'b1 || sif.done !== 1'b0)
      $display("FAIL wrap_hold: got zero=%b c_out=%b done=%b want 1 1 0", sif.zero, sif.c_out, sif.done);
    else passed++;
  endtask

  task automatic test_sub_borrow();
    int edges;
    issue(4'b0011, 4'b0101, 1'b1);
    wait_done(edges);
    checks++;
    if ({sif.result, sif.c_out, sif.ovf, sif.zero} !== {4'b1110, 1'b0, 1'b0, 1'b0} || edges !== W)
      $display("FAIL sub_borrow: got result=%b c_out=%b ovf=%b zero=%b edges=%0d want 1110 0 0 0 %0d",
               sif.result, sif.c_out, sif.ovf, sif.zero, edges, W);
    else passed++;
    issue(4'b0110, 4'b0010, 1'b1);
    wait_done(edges);
    checks++;
    if ({sif.result, sif.c_out, sif.ovf} !== {4'b0100, 1'b1, 1'b0})
      $display("FAIL sub_no_borrow: got result=%b c_out=%b ovf=%b want 0100 1 0", sif.result, sif.c_out, sif.ovf);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int edges;
    int pulses;
    issue(4'b0010, 4'b0011, 1'b0);
    @(posedge clk); #1;
    sif.start = 1'b1; sif.a = 4'b1111; sif.b = 4'b1111; sif.op_sub = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    edges = 2;
    while (sif.done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (sif.result !== 4'b0101 || sif.c_out !== 1'b0 || edges !== W)
      $display("FAIL busy_start_ignored: got result=%b c_out=%b edges=%0d want 0101 0 %0d", sif.result, sif.c_out, edges, W);
    else passed++;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sif.done === 1'b1 || sif.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL busy_single_done: got %0d extra busy/done cycles want 0", pulses);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int edges;
    issue(4'b0001, 4'b0001, 1'b0);
    wait_done(edges);
    sif.start = 1'b1; sif.a = 4'b0101; sif.b = 4'b0110; sif.op_sub = 1'b0;
    checks++;
    if (sif.done !== 1'b1 || sif.result !== 4'b0010)
      $display("FAIL b2b_first: got done=%b result=%b want 1 0010", sif.done, sif.result);
    else passed++;
    @(posedge clk); #1;
    sif.start = 1'b0;
    checks++;
    if (sif.busy !== 1'b1 || sif.done !== 1'b0)
      $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", sif.busy, sif.done);
    else passed++;
    wait_done(edges);
    checks++;
    if ({sif.result, sif.c_out, sif.ovf} !== {4'b1011, 1'b0, OVF_ON} || edges !== W)
      $display("FAIL b2b_second: got result=%b c_out=%b ovf=%b edges=%0d want 1011 0 %b %0d",
               sif.result, sif.c_out, sif.ovf, edges, OVF_ON, W);
    else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int pulses;
    issue(4'b0111, 4'b0111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sif.busy, sif.done, sif.result, sif.c_out, sif.ovf, sif.zero} !== 9'b0)
      $display("FAIL reset_mid_shift: got busy=%b done=%b result=%b c_out=%b ovf=%b zero=%b want all 0",
               sif.busy, sif.done, sif.result, sif.c_out, sif.ovf, sif.zero);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (sif.done === 1'b1 || sif.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL reset_no_done: got %0d busy/done cycles want 0", pulses);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_add_overflow();
    test_add_wrap();
    test_sub_borrow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
